mult_dsp_slice: RTL and testbench
=================================

MULT_DSP_SLICE -- requirements
Module: mult_dsp_slice

Interface
REQ-001 Parameter WIDTH, default 36: operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter PIPE_STAGES, default 2: input-to-output latency in cycles; legal range 1..4.
REQ-003 Parameter CFG_BITS, fixed 3: length of the configuration chain (mode[1:0], signed).
REQ-004 prog_clk  input  1  sole clock; datapath and configuration chain use it, rising edge.
REQ-005 pReset  input  1  reset; synchronous and active-high.
REQ-006 cfg_en  input  1  configuration shift enable.
REQ-007 ccff_head  input  1  configuration chain serial input.
REQ-008 ccff_tail  output  1  configuration chain serial output.
REQ-009 in_valid  input  1  operands valid this cycle.
REQ-010 acc_clr  input  1  MAC mode: start a new accumulation with this operand pair.
REQ-011 mult_A  input  WIDTH  operand A; bit 0 is the MSB.
REQ-012 mult_B  input  WIDTH  operand B; bit 0 is the MSB.
REQ-013 out_valid  output  1  mult_Y holds a new result.
REQ-014 mult_Y  output  2*WIDTH  product or accumulator; bit 0 is the MSB.

Function
REQ-015 Config chain: when cfg_en=1, cfg[0]<=ccff_head and cfg[i]<=cfg[i-1]; ccff_tail=cfg[2] combinationally; the chain holds when cfg_en=0.
REQ-016 Config decode: mode[1]=cfg[0], mode[0]=cfg[1], signed=cfg[2]. Shifting in 1,1,0 (first bit first) gives mode=01 and signed=1.
REQ-017 Mode 00: a single WIDTH x WIDTH product of mult_A and mult_B, 2*WIDTH bits wide.
REQ-018 Mode 01: two independent (WIDTH/2)^2 lanes. Lane 0 uses the MSB halves of A and B and writes the MSB half of mult_Y.
REQ-019 Mode 10: four independent (WIDTH/4)^2 lanes with the same MSB-first lane ordering. Each lane result is WIDTH/2 bits.
REQ-020 Mode 11 (MAC): full-width product added to the accumulator acc (2*WIDTH bits), wrapping modulo 2^(2*WIDTH); mult_Y=acc.
REQ-021 MAC clear: when acc_clr=1, acc loads the product instead of adding it. acc_clr is ignored when in_valid=0 and in modes other than 11.
REQ-022 signed=1: all lanes use two's-complement operands and results, sign-extended within each lane field. signed=0: all lanes are unsigned.
REQ-023 Pipeline: operands are captured when in_valid=1 and cfg_en=0. The result and out_valid appear exactly PIPE_STAGES cycles later. out_valid is a one-cycle pulse per accepted input. Full throughput is one operand pair per cycle; there is no backpressure.
REQ-024 The MAC accumulate happens in the final stage, so back-to-back MAC inputs SHALL chain correctly with no bubbles.
REQ-025 mult_Y holds its last value when out_valid=0.
REQ-026 When cfg_en=1, in_valid is ignored and all in-flight valid bits clear on that edge, so no out_valid is produced for operands accepted before the flush. acc and mult_Y hold their values.
REQ-027 Mode and signed are sampled with the operands at capture. Results in flight use their capture-time configuration.

Reset
REQ-028 pReset=1 at a rising edge SHALL clear cfg (mode=00, signed=0), all pipeline registers and valid bits, acc, mult_Y and out_valid to 0. ccff_tail becomes 0.
REQ-029 pReset has priority over cfg_en and in_valid. A reset mid-operation discards in-flight results, and out_valid stays 0 until PIPE_STAGES cycles after the next accepted input.

Verification (WIDTH=36, PIPE_STAGES=2)
REQ-030 Reset: assert pReset for 1 cycle during traffic -> out_valid=0, mult_Y=0, ccff_tail=0 from the next cycle.
REQ-031 Mode 00 unsigned: A=36'hF_FFFF_FFFF, B=2, in_valid for one cycle -> two cycles later out_valid=1 for one cycle and Y=72'h1F_FFFF_FFFE.
REQ-032 Mode 00 signed (shift 1,0,0): A=-3, B=5 -> Y=72'hFF_FFFF_FFFF_FFFF_FFF1.
REQ-033 Mode 01 unsigned (shift 0,1,0): A={18'd3,18'd4}, B={18'd5,18'd6} -> Y={36'd15,36'd24}. Also check mode 10 with A=B={9'd2,9'd3,9'd4,9'd5} -> Y={18'd4,18'd9,18'd16,18'd25}.
REQ-034 Mode 11 (shift 0,1,1): consecutive inputs (2,3,acc_clr=1), (4,5,0), (1,1,0) -> Y=6, 26, 27 on consecutive cycles. Then acc_clr with (7,1) -> Y=7.
REQ-035 Flush: accept in_valid with A=B=1, raise cfg_en the next cycle -> out_valid never asserts and mult_Y is unchanged. Also check wrap: acc=2^72-1 plus product 1 -> Y=0.

Source files
------------

// File: rtl/mult_dsp_slice.sv
// Configurable DSP multiplier slice: one full-width, two half-width or four quarter-width
// lanes, or a full-width MAC, selected by a 3-bit serial configuration chain.
module mult_dsp_slice #(
  parameter int WIDTH       = 36,
  parameter int PIPE_STAGES = 2
) (
  input  logic               prog_clk,
  input  logic               pReset,
  input  logic               cfg_en,
  input  logic               ccff_head,
  output logic               ccff_tail,
  input  logic               in_valid,
  input  logic               acc_clr,
  input  logic [0:WIDTH-1]   mult_A,
  input  logic [0:WIDTH-1]   mult_B,
  output logic               out_valid,
  output logic [0:2*WIDTH-1] mult_Y
);

  localparam int CFG_BITS = 3;
  localparam int HALF     = WIDTH / 2;
  localparam int QTR      = WIDTH / 4;
  localparam int YW       = 2 * WIDTH;

  logic [CFG_BITS-1:0] cfg;
  logic [1:0]          mode;
  logic                is_signed;
  logic [WIDTH-1:0]    a_val;
  logic [WIDTH-1:0]    b_val;
  logic                accept;

  logic [YW-1:0]       a_full;
  logic [YW-1:0]       b_full;
  logic [WIDTH-1:0]    a_half;
  logic [WIDTH-1:0]    b_half;
  logic [HALF-1:0]     a_qtr;
  logic [HALF-1:0]     b_qtr;
  logic [YW-1:0]       full_prod;
  logic [YW-1:0]       half_prod;
  logic [YW-1:0]       qtr_prod;
  logic [YW-1:0]       prod;

  logic                fin_valid;
  logic                fin_mac;
  logic                fin_clr;
  logic [YW-1:0]       fin_prod;
  logic [YW-1:0]       acc;
  logic [YW-1:0]       acc_next;
  logic [YW-1:0]       y_q;

  assign mode      = {cfg[0], cfg[1]};
  assign is_signed = cfg[2];
  assign ccff_tail = cfg[2];
  assign a_val     = mult_A;
  assign b_val     = mult_B;
  assign accept    = in_valid & ~cfg_en;
  assign mult_Y    = y_q;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      cfg <= '0;
    end else if (cfg_en) begin
      cfg <= {cfg[CFG_BITS-2:0], ccff_head};
    end
  end

  // Lane products are packed so lane k of the operands lands in lane k of the result;
  // each operand is extended to the lane result width so the product wraps per lane.
  always_comb begin
    a_full    = {{WIDTH{is_signed & a_val[WIDTH-1]}}, a_val};
    b_full    = {{WIDTH{is_signed & b_val[WIDTH-1]}}, b_val};
    full_prod = a_full * b_full;
    a_half    = '0;
    b_half    = '0;
    a_qtr     = '0;
    b_qtr     = '0;
    half_prod = '0;
    qtr_prod  = '0;
    for (int i = 0; i < 2; i++) begin
      a_half = {{HALF{is_signed & a_val[i*HALF+HALF-1]}}, a_val[i*HALF +: HALF]};
      b_half = {{HALF{is_signed & b_val[i*HALF+HALF-1]}}, b_val[i*HALF +: HALF]};
      half_prod[i*WIDTH +: WIDTH] = a_half * b_half;
    end
    for (int i = 0; i < 4; i++) begin
      a_qtr = {{QTR{is_signed & a_val[i*QTR+QTR-1]}}, a_val[i*QTR +: QTR]};
      b_qtr = {{QTR{is_signed & b_val[i*QTR+QTR-1]}}, b_val[i*QTR +: QTR]};
      qtr_prod[i*HALF +: HALF] = a_qtr * b_qtr;
    end
    case (mode)
      2'b01:   prod = half_prod;
      2'b10:   prod = qtr_prod;
      default: prod = full_prod;
    endcase
  end

  generate
    if (PIPE_STAGES == 1) begin : g_direct
      assign fin_valid = accept;
      assign fin_mac   = (mode == 2'b11);
      assign fin_clr   = acc_clr;
      assign fin_prod  = prod;
    end else begin : g_pipe
      logic [PIPE_STAGES-2:0] valid_q;
      logic [PIPE_STAGES-2:0] mac_q;
      logic [PIPE_STAGES-2:0] clr_q;
      logic [YW-1:0]          prod_q [PIPE_STAGES-1];

      // Products travel with their capture-time mode; a config shift kills all in-flight valids.
      always_ff @(posedge prog_clk) begin
        if (pReset) begin
          valid_q <= '0;
          mac_q   <= '0;
          clr_q   <= '0;
          for (int i = 0; i < PIPE_STAGES - 1; i++) begin
            prod_q[i] <= '0;
          end
        end else begin
          valid_q[0] <= accept;
          mac_q[0]   <= (mode == 2'b11);
          clr_q[0]   <= acc_clr;
          prod_q[0]  <= prod;
          for (int i = 1; i < PIPE_STAGES - 1; i++) begin
            valid_q[i] <= valid_q[i-1] & ~cfg_en;
            mac_q[i]   <= mac_q[i-1];
            clr_q[i]   <= clr_q[i-1];
            prod_q[i]  <= prod_q[i-1];
          end
        end
      end

      assign fin_valid = valid_q[PIPE_STAGES-2] & ~cfg_en;
      assign fin_mac   = mac_q[PIPE_STAGES-2];
      assign fin_clr   = clr_q[PIPE_STAGES-2];
      assign fin_prod  = prod_q[PIPE_STAGES-2];
    end
  endgenerate

  assign acc_next = fin_clr ? fin_prod : acc + fin_prod;

  // Accumulating in the output stage lets back-to-back MAC inputs chain without bubbles.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      acc       <= '0;
      y_q       <= '0;
      out_valid <= 1'b0;
    end else if (cfg_en) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        if (fin_mac) begin
          acc <= acc_next;
          y_q <= acc_next;
        end else begin
          y_q <= fin_prod;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_dsp_slice.sv
// Self-checking bench for mult_dsp_slice: directed vectors plus random traffic
// compared against a per-lane arithmetic reference model with a transaction queue.
module tb_mult_dsp_slice;

  localparam int W = 36;
  localparam int P = 2;

  logic          prog_clk = 1'b0;
  logic          pReset;
  logic          cfg_en;
  logic          ccff_head;
  logic          ccff_tail;
  logic          in_valid;
  logic          acc_clr;
  logic [0:W-1]  mult_A;
  logic [0:W-1]  mult_B;
  logic          out_valid;
  logic [0:2*W-1] mult_Y;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int          due;
    logic        mac;
    logic        clr;
    logic [71:0] prod;
  } txn_t;

  txn_t        pend[$];
  int          cyc = 0;
  logic [2:0]  newest_bits = '0;
  logic [71:0] m_acc = '0;
  logic [71:0] m_y = '0;
  logic        m_ov = 1'b0;

  mult_dsp_slice #(.WIDTH(W), .PIPE_STAGES(P)) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .cfg_en    (cfg_en),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .in_valid  (in_valid),
    .acc_clr   (acc_clr),
    .mult_A    (mult_A),
    .mult_B    (mult_B),
    .out_valid (out_valid),
    .mult_Y    (mult_Y)
  );

  always #5 prog_clk = ~prog_clk;

  // Lane k = 0 is the most significant lane; each lane is an independent product wrapped to its field.
  function automatic logic [71:0] model_prod(input logic [1:0] mode, input logic sgn,
                                             input logic [35:0] a, input logic [35:0] b);
    int lanes;
    int lw;
    logic signed [159:0] va;
    logic signed [159:0] vb;
    logic signed [159:0] p;
    logic [159:0] field;
    logic [71:0] res;
    lanes = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
    lw = 36 / lanes;
    res = '0;
    for (int k = 0; k < lanes; k++) begin
      va = 160'((a >> (36 - (k + 1) * lw)) & ((36'd1 << lw) - 36'd1));
      vb = 160'((b >> (36 - (k + 1) * lw)) & ((36'd1 << lw) - 36'd1));
      if (sgn && va[lw-1]) va = va - (160'sd1 <<< lw);
      if (sgn && vb[lw-1]) vb = vb - (160'sd1 <<< lw);
      p = va * vb;
      field = p & ((160'd1 << (2 * lw)) - 160'd1);
      res = res | 72'(field << ((lanes - 1 - k) * 2 * lw));
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then compare all outputs.
  task automatic applyStimulus(input logic rst, input logic ce, input logic head, input logic iv,
                               input logic clr, input logic [35:0] a, input logic [35:0] b);
    logic [1:0] mode;
    logic       sgn;
    txn_t       t;
    pReset = rst; cfg_en = ce; ccff_head = head; in_valid = iv; acc_clr = clr;
    mult_A = a; mult_B = b;
    @(posedge prog_clk);
    #1;
    cyc++;
    if (rst) begin
      pend.delete(); m_acc = '0; m_y = '0; m_ov = 1'b0; newest_bits = '0;
    end else if (ce) begin
      pend.delete(); m_ov = 1'b0;
      newest_bits = {newest_bits[1:0], head};
    end else begin
      mode = {newest_bits[0], newest_bits[1]};
      sgn  = newest_bits[2];
      if (iv) pend.push_back('{cyc + P - 1, mode == 2'b11, clr, model_prod(mode, sgn, a, b)});
      m_ov = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        t = pend.pop_front();
        m_ov = 1'b1;
        if (t.mac) begin
          m_acc = t.clr ? t.prod : m_acc + t.prod;
          m_y = m_acc;
        end else begin
          m_y = t.prod;
        end
      end
    end
    checkOutput("model_out_valid", 72'(out_valid), 72'(m_ov));
    checkOutput("model_mult_Y", mult_Y, m_y);
    checkOutput("model_ccff_tail", 72'(ccff_tail), 72'(newest_bits[2]));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'd0, 36'd0);
  endtask

  task automatic feed(input logic [35:0] a, input logic [35:0] b, input logic clr);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, clr, a, b);
  endtask

  task automatic shiftCfg(input logic b0, input logic b1, input logic b2);
    applyStimulus(1'b0, 1'b1, b0, 1'b0, 1'b0, 36'd0, 36'd0);
    applyStimulus(1'b0, 1'b1, b1, 1'b0, 1'b0, 36'd0, 36'd0);
    applyStimulus(1'b0, 1'b1, b2, 1'b0, 1'b0, 36'd0, 36'd0);
  endtask

  initial begin
    int r;
    logic [35:0] ra;
    logic [35:0] rb;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 36'd0, 36'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 36'd0, 36'd0);
    checkOutput("reset_y", mult_Y, 72'd0);
    checkOutput("reset_ov", 72'(out_valid), 72'd0);

    feed(36'hF_FFFF_FFFF, 36'd2, 1'b0);
    idle();
    checkOutput("m00u_ov", 72'(out_valid), 72'd1);
    checkOutput("m00u_y", mult_Y, 72'h1F_FFFF_FFFE);
    idle();
    checkOutput("m00u_pulse", 72'(out_valid), 72'd0);
    checkOutput("m00u_hold", mult_Y, 72'h1F_FFFF_FFFE);

    shiftCfg(1'b1, 1'b0, 1'b0);
    feed(36'hF_FFFF_FFFD, 36'd5, 1'b0);
    idle();
    checkOutput("m00s_y", mult_Y, 72'hFF_FFFF_FFFF_FFFF_FFF1);

    shiftCfg(1'b0, 1'b1, 1'b0);
    feed({18'd3, 18'd4}, {18'd5, 18'd6}, 1'b0);
    idle();
    checkOutput("m01u_y", mult_Y, {36'd15, 36'd24});

    shiftCfg(1'b0, 1'b0, 1'b1);
    feed({9'd2, 9'd3, 9'd4, 9'd5}, {9'd2, 9'd3, 9'd4, 9'd5}, 1'b0);
    idle();
    checkOutput("m10u_y", mult_Y, {18'd4, 18'd9, 18'd16, 18'd25});

    shiftCfg(1'b0, 1'b1, 1'b1);
    feed(36'd2, 36'd3, 1'b1);
    feed(36'd4, 36'd5, 1'b0);
    checkOutput("mac_y6", mult_Y, 72'd6);
    feed(36'd1, 36'd1, 1'b0);
    checkOutput("mac_y26", mult_Y, 72'd26);
    idle();
    checkOutput("mac_y27", mult_Y, 72'd27);
    feed(36'd7, 36'd1, 1'b1);
    idle();
    checkOutput("mac_clr_y7", mult_Y, 72'd7);

    feed(36'd1, 36'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 36'd0, 36'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput("flush_ov", 72'(out_valid), 72'd0);
      checkOutput("flush_hold", mult_Y, 72'd7);
    end

    shiftCfg(1'b1, 1'b1, 1'b1);
    feed(36'hF_FFFF_FFFF, 36'd1, 1'b1);
    feed(36'd1, 36'd1, 1'b0);
    checkOutput("wrap_load", mult_Y, {72{1'b1}});
    idle();
    checkOutput("wrap_zero", mult_Y, 72'd0);

    feed(36'd3, 36'd4, 1'b1);
    feed(36'd5, 36'd6, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 36'd9, 36'd9);
    checkOutput("rst_mid_ov", 72'(out_valid), 72'd0);
    checkOutput("rst_mid_y", mult_Y, 72'd0);
    checkOutput("rst_mid_tail", 72'(ccff_tail), 72'd0);
    idle();
    checkOutput("rst_discard_ov", 72'(out_valid), 72'd0);
    feed(36'd6, 36'd7, 1'b0);
    idle();
    checkOutput("rst_recover_y", mult_Y, 72'd42);

    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 99);
      ra = 36'({$urandom(), $urandom()});
      rb = 36'({$urandom(), $urandom()});
      if ($urandom_range(0, 7) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = 36'h8_0000_0000;
      if (r < 2)
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ra, rb);
      else if (r < 10)
        applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, ra, rb);
      else
        applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 9) < 7),
                      1'($urandom_range(0, 3) == 0), ra, rb);
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
